noc_input_unit: RTL and testbench

- Router input port placed directly upstream of the lookahead routing stage; one instance per input port of the 2D-mesh router.
- Buffers incoming flits in a small FIFO and presents the head flit's destination and routing direction to the lookahead routing logic.
- Rewrites the head flit's routing field with the returned next-hop direction.
- Raises a one-hot switch request and holds it for the whole packet (wormhole) until the tail flit is granted.

---
 rtl/noc_input_unit_if.sv | 42 ++++
 rtl/noc_input_unit.sv | 103 ++++++++++
 tb/tb_noc_input_unit.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_input_unit_if.sv
// noc_input_unit_if: flit types and the handshake bundle between a router input port and its neighbours
package noc;
    typedef logic [4:0] direction_t;
    localparam direction_t GO_LOCAL = 5'b00001;
    localparam direction_t GO_NORTH = 5'b00010;
    localparam direction_t GO_EAST  = 5'b00100;
    localparam direction_t GO_SOUTH = 5'b01000;
    localparam direction_t GO_WEST  = 5'b10000;
    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } xy_t;
    typedef struct packed {
        logic       head;
        logic       tail;
        xy_t        destination;
        direction_t routing;
        logic [31:0] payload;
    } flit_t;
endpackage

interface noc_input_unit_if;
    import noc::*;
    flit_t      data_in;
    logic       data_void_in;
    logic       stop_out;
    xy_t        la_destination;
    direction_t la_current_routing;
    direction_t la_next_routing;
    direction_t req_out;
    logic       gnt_in;
    flit_t      data_out;
    logic       data_void_out;
    modport slave (
        input  data_in, data_void_in, la_next_routing, gnt_in,
        output stop_out, la_destination, la_current_routing, req_out, data_out, data_void_out
    );
    modport master (
        output data_in, data_void_in, la_next_routing, gnt_in,
        input  stop_out, la_destination, la_current_routing, req_out, data_out, data_void_out
    );
endinterface

// File: rtl/noc_input_unit.sv
// noc_input_unit: wormhole input port with flit FIFO, lookahead routing rewrite and locked switch request; NOC_INPUT_UNIT_PERF_EN adds packet/stall counters
module noc_input_unit
    import noc::*;
#(
    parameter int Depth   = 4,
    parameter int PortIdx = 0
) (
    input  logic        clk,
    input  logic        rst,
    noc_input_unit_if.slave bus
`ifdef NOC_INPUT_UNIT_PERF_EN
    ,
    output logic [31:0] pkt_count,
    output logic [31:0] stall_count
`endif
);
    localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CW = $clog2(Depth + 1);
    localparam direction_t PortDir = direction_t'(5'b1 << PortIdx);

    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

    flit_t          mem [Depth];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    state_t         state, cur;
    direction_t     lock, req;
    flit_t          front, popped;
    logic           empty, full, legal, push, pop;

    // A head reaching the front of an idle port is acted on in the same cycle
    always_comb begin
        empty  = count == '0;
        full   = count == CW'(Depth);
        front  = mem[rd_ptr];
        cur    = (state == IDLE && !empty && front.head) ? HEAD : state;
        legal  = $onehot(front.routing) && front.routing != PortDir;
        req    = (cur == HEAD && !empty && legal) ? front.routing :
                 (cur == BODY && !empty) ? lock : '0;
        pop    = bus.gnt_in && req != '0;
        push   = !bus.data_void_in && !full;
        popped = front;
        popped.routing = front.head ? bus.la_next_routing : front.routing;
    end

    assign bus.stop_out           = full;
    assign bus.la_destination     = front.destination;
    assign bus.la_current_routing = front.routing;
    assign bus.req_out            = req;

    // Flit storage; contents are meaningless while the count says empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.data_in;
    end

    // Pointers, occupancy, packet FSM, request lock and the output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            state         <= IDLE;
            lock          <= '0;
            data_reset();
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= (rd_ptr == PW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            state <= (cur == HEAD) ? (pop ? (front.tail ? IDLE : BODY) : HEAD) :
                     (cur == BODY) ? ((pop && front.tail) ? IDLE : BODY) : IDLE;
            if (pop) lock <= front.tail ? '0 : (cur == HEAD ? req : lock);
            bus.data_void_out <= !pop;
            if (pop) bus.data_out <= popped;
        end
    end

    task automatic data_reset();
        bus.data_out      <= '0;
        bus.data_void_out <= 1'b1;
    endtask

`ifdef NOC_INPUT_UNIT_PERF_EN
    // Delivered packets and cycles spent requesting without a grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_count   <= '0;
            stall_count <= '0;
        end else begin
            if (pop && front.tail) pkt_count <= pkt_count + 1'b1;
            if (req != '0 && !bus.gnt_in) stall_count <= stall_count + 1'b1;
        end
    end
`endif

`ifndef SYNTHESIS
    a_overflow: assert property (@(posedge clk) disable iff (!rst) !(full && !bus.data_void_in))
        else $warning("noc_input_unit: write while full, flit dropped");
    a_bad_head: assert property (@(posedge clk) disable iff (!rst) !(cur == HEAD && !empty && !legal))
        else $warning("noc_input_unit: head routing not one-hot or U-turn, port stalled");
    a_orphan: assert property (@(posedge clk) disable iff (!rst) !(cur == IDLE && !empty))
        else $warning("noc_input_unit: non-head flit at front while idle, held");
`endif
endmodule

// File: tb/tb_noc_input_unit.sv
// tb_noc_input_unit: directed checks of the input unit with hand-computed expectations
module tb_noc_input_unit;
    import noc::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;
    int   failed = 0;

    noc_input_unit_if bus();
`ifdef NOC_INPUT_UNIT_PERF_EN
    logic [31:0] pkt_count, stall_count;
`endif

    noc_input_unit #(.Depth(4), .PortIdx(0)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef NOC_INPUT_UNIT_PERF_EN
        ,
        .pkt_count(pkt_count),
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic flit_t mk(logic h, logic t, logic [3:0] x, logic [3:0] y, direction_t r, logic [31:0] p);
        flit_t f;
        f.head = h;
        f.tail = t;
        f.destination.x = x;
        f.destination.y = y;
        f.routing = r;
        f.payload = p;
        return f;
    endfunction

    function automatic flit_t rew(flit_t f, direction_t r);
        flit_t g;
        g = f;
        g.routing = r;
        return g;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        #2 rst = 1'b1;
    endtask

    flit_t f1, h2, b2, t2, h4, b4, t4, h5, b5, b5b, orphan, bad, uturn;
    flit_t p [5];

    initial begin
        bus.data_in = '0;
        bus.data_void_in = 1'b1;
        bus.gnt_in = 1'b0;
        bus.la_next_routing = '0;
        #1 rst = 1'b0;
        #2;
        chk("rst_stop", 64'(bus.stop_out), 64'd0);
        chk("rst_req", 64'(bus.req_out), 64'd0);
        chk("rst_void", 64'(bus.data_void_out), 64'd1);
        chk("rst_data", 64'(bus.data_out), 64'd0);
        #8 rst = 1'b1;

        // single-flit packet
        f1 = mk(1, 1, 4'd2, 4'd1, GO_EAST, 32'h100);
        bus.data_in = f1;
        bus.data_void_in = 1'b0;
        bus.gnt_in = 1'b1;
        bus.la_next_routing = GO_SOUTH;
        tick();
        bus.data_void_in = 1'b1;
        chk("t1_req", 64'(bus.req_out), 64'(GO_EAST));
        chk("t1_la_dest", 64'(bus.la_destination), 64'h21);
        chk("t1_void_pre", 64'(bus.data_void_out), 64'd1);
        tick();
        chk("t1_void", 64'(bus.data_void_out), 64'd0);
        chk("t1_data", 64'(bus.data_out), 64'(rew(f1, GO_SOUTH)));
        chk("t1_idle_req", 64'(bus.req_out), 64'd0);
        bus.gnt_in = 1'b0;

        // 3-flit packet, grant two cycles late
        h2 = mk(1, 0, 4'd1, 4'd3, GO_NORTH, 32'h200);
        b2 = mk(0, 0, 4'd1, 4'd3, 5'b00100, 32'h201);
        t2 = mk(0, 1, 4'd1, 4'd3, 5'b01000, 32'h202);
        bus.data_in = h2;
        bus.data_void_in = 1'b0;
        tick();
        chk("t2_req_h0", 64'(bus.req_out), 64'(GO_NORTH));
        bus.data_in = b2;
        tick();
        chk("t2_req_h1", 64'(bus.req_out), 64'(GO_NORTH));
        bus.data_in = t2;
        tick();
        bus.data_void_in = 1'b1;
        chk("t2_req_h2", 64'(bus.req_out), 64'(GO_NORTH));
        bus.gnt_in = 1'b1;
        bus.la_next_routing = GO_WEST;
        tick();
        chk("t2_head_out", 64'(bus.data_out), 64'(rew(h2, GO_WEST)));
        chk("t2_req_body", 64'(bus.req_out), 64'(GO_NORTH));
        tick();
        chk("t2_body_out", 64'(bus.data_out), 64'(b2));
        chk("t2_req_tail", 64'(bus.req_out), 64'(GO_NORTH));
        tick();
        chk("t2_tail_out", 64'(bus.data_out), 64'(t2));
        chk("t2_req_done", 64'(bus.req_out), 64'd0);
        bus.gnt_in = 1'b0;
        bus.la_next_routing = GO_SOUTH;
        tick();
        chk("t2_void_after", 64'(bus.data_void_out), 64'd1);
        chk("t2_data_hold", 64'(bus.data_out), 64'(t2));

        // fill to Depth with no grant, then one overflow attempt
        for (int i = 0; i < 5; i++) p[i] = mk(1, 1, 4'(i), 4'd0, GO_EAST, 32'h300 + 32'(i));
        bus.data_void_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.data_in = p[i];
            tick();
            chk("t3_stop_fill", 64'(bus.stop_out), (i == 3) ? 64'd1 : 64'd0);
        end
        bus.data_in = p[4];
        tick();
        chk("t3_stop_over", 64'(bus.stop_out), 64'd1);
        bus.data_void_in = 1'b1;
        bus.gnt_in = 1'b1;
        tick();
        chk("t3_stop_drop", 64'(bus.stop_out), 64'd0);
        chk("t3_pop0", 64'(bus.data_out), 64'(rew(p[0], GO_SOUTH)));
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("t3_drain", 64'(bus.data_out), 64'(rew(p[i], GO_SOUTH)));
        end
        chk("t3_empty_req", 64'(bus.req_out), 64'd0);
        bus.gnt_in = 1'b0;
        tick();
        chk("t3_void", 64'(bus.data_void_out), 64'd1);

        // body underflow between body and tail
        h4 = mk(1, 0, 4'd3, 4'd3, GO_EAST, 32'h400);
        b4 = mk(0, 0, 4'd3, 4'd3, 5'b00001, 32'h401);
        t4 = mk(0, 1, 4'd3, 4'd3, 5'b00001, 32'h402);
        bus.gnt_in = 1'b1;
        bus.data_in = h4;
        bus.data_void_in = 1'b0;
        tick();
        bus.data_in = b4;
        chk("t4_req_head", 64'(bus.req_out), 64'(GO_EAST));
        tick();
        bus.data_void_in = 1'b1;
        chk("t4_head_out", 64'(bus.data_out), 64'(rew(h4, GO_SOUTH)));
        chk("t4_req_body", 64'(bus.req_out), 64'(GO_EAST));
        tick();
        chk("t4_body_out", 64'(bus.data_out), 64'(b4));
        chk("t4_req_gap0", 64'(bus.req_out), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_req_gap", 64'(bus.req_out), 64'd0);
            chk("t4_void_gap", 64'(bus.data_void_out), 64'd1);
        end
        bus.data_in = t4;
        bus.data_void_in = 1'b0;
        tick();
        bus.data_void_in = 1'b1;
        chk("t4_req_tail", 64'(bus.req_out), 64'(GO_EAST));
        tick();
        chk("t4_tail_out", 64'(bus.data_out), 64'(t4));
        chk("t4_req_done", 64'(bus.req_out), 64'd0);
        bus.gnt_in = 1'b0;

        // reset while in BODY with two flits buffered
        h5  = mk(1, 0, 4'd0, 4'd2, GO_NORTH, 32'h500);
        b5  = mk(0, 0, 4'd0, 4'd2, 5'b00001, 32'h501);
        b5b = mk(0, 0, 4'd0, 4'd2, 5'b00001, 32'h502);
        bus.data_void_in = 1'b0;
        bus.data_in = h5;
        tick();
        bus.data_in = b5;
        tick();
        bus.data_in = b5b;
        tick();
        bus.data_void_in = 1'b1;
        bus.gnt_in = 1'b1;
        tick();
        bus.gnt_in = 1'b0;
        chk("t5_req_body", 64'(bus.req_out), 64'(GO_NORTH));
        chk("t5_void_pre", 64'(bus.data_void_out), 64'd0);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_stop", 64'(bus.stop_out), 64'd0);
        chk("t5_rst_req", 64'(bus.req_out), 64'd0);
        chk("t5_rst_void", 64'(bus.data_void_out), 64'd1);
        chk("t5_rst_data", 64'(bus.data_out), 64'd0);
        #2 rst = 1'b1;
        // leftover body flit from upstream lands in an idle port and is held
        orphan = mk(0, 1, 4'd0, 4'd2, 5'b00001, 32'h503);
        bus.data_in = orphan;
        bus.data_void_in = 1'b0;
        tick();
        bus.data_void_in = 1'b1;
        bus.gnt_in = 1'b1;
        chk("t5_orphan_req", 64'(bus.req_out), 64'd0);
        tick();
        chk("t5_orphan_hold", 64'(bus.data_void_out), 64'd1);
        bus.gnt_in = 1'b0;
        do_reset();

        // illegal non-one-hot head
        bad = mk(1, 1, 4'd1, 4'd1, 5'b00011, 32'h600);
        bus.data_in = bad;
        bus.data_void_in = 1'b0;
        bus.gnt_in = 1'b1;
        tick();
        bus.data_void_in = 1'b1;
        chk("t6_bad_req", 64'(bus.req_out), 64'd0);
        tick();
        chk("t6_bad_nopop", 64'(bus.data_void_out), 64'd1);
        chk("t6_bad_req2", 64'(bus.req_out), 64'd0);
        bus.gnt_in = 1'b0;
        do_reset();

        // U-turn head back to port 0 (local)
        uturn = mk(1, 1, 4'd1, 4'd1, GO_LOCAL, 32'h700);
        bus.data_in = uturn;
        bus.data_void_in = 1'b0;
        bus.gnt_in = 1'b1;
        tick();
        bus.data_void_in = 1'b1;
        chk("t7_uturn_req", 64'(bus.req_out), 64'd0);
        tick();
        chk("t7_uturn_nopop", 64'(bus.data_void_out), 64'd1);
        bus.gnt_in = 1'b0;
        do_reset();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
